func4_sweep_ctrl: RTL

Sequencer for the 4-bit `func4` classifier, which is combinational with input `a[3:0]` and outputs `p` (prime) and `d` (divisible by 3). On a start request it sweeps `a` over a programmed inclusive range. After a programmable settle time it samples `p`/`d` for each code and builds result bitmaps and population counts. It sits between a host/test controller and the `func4` instance and gives the host a start/busy/done handshake.

---
 rtl/func4_sweep_pkg.sv | 19 +
 rtl/func4.sv | 30 +++
 rtl/func4_sweep_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/func4_sweep_pkg.sv
// Shared types and constants for the func4 range-sweep sequencer.
package func4_sweep_pkg;

    // Width of the population counters; 16 codes need values 0..16.
    localparam int CNT_W = 5;

    // Reference classification of every 4-bit code.
    // Primes are 2, 3, 5, 7, 11, 13. Multiples of 3 are 0, 3, 6, 9, 12, 15.
    localparam logic [15:0] PRIME_GOLDEN = 16'h28AC;
    localparam logic [15:0] DIV3_GOLDEN  = 16'h9249;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } sweep_state_e;

endpackage

// File: rtl/func4.sv
// func4: combinational classifier of a 4-bit code.
// p = code is prime, d = code is divisible by 3 (0 counts as divisible).
module func4 (
    input  logic [3:0] a,
    output logic       p,
    output logic       d
);

    // Decode each code into its prime / divisible-by-3 flags.
    always_comb begin
        // NOTE: give every output a default before the case so that no path leaves it unassigned (no latch).
        p = 1'b0;
        d = 1'b0;
        case (a)
            4'd0:  d = 1'b1;
            4'd2:  p = 1'b1;
            4'd3:  begin p = 1'b1; d = 1'b1; end
            4'd5:  p = 1'b1;
            4'd6:  d = 1'b1;
            4'd7:  p = 1'b1;
            4'd9:  d = 1'b1;
            4'd11: p = 1'b1;
            4'd12: d = 1'b1;
            4'd13: p = 1'b1;
            4'd15: d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/func4_sweep_ctrl.sv
// func4_sweep_ctrl: sweeps the func4 input over an inclusive range [lo, hi],
// waits SETTLE_CYC cycles per code, samples p/d into bitmaps and counts,
// and reports through a start/busy/done handshake.
// Optional build macro FUNC4_SWEEP_CHECK_EN: compares every sample against
// the golden tables and drives err/err_cnt; otherwise both are tied to 0.
module func4_sweep_ctrl
    import func4_sweep_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       lo,
    input  logic [3:0]       hi,
    output logic [3:0]       a,
    input  logic             p,
    input  logic             d,
    output logic             busy,
    output logic             done,
    output logic [15:0]      prime_mask,
    output logic [15:0]      div3_mask,
    output logic [CNT_W-1:0] prime_cnt,
    output logic [CNT_W-1:0] div3_cnt,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    // Wait counter reload: DRIVE lasts SETTLE_CYC cycles (counts down to 0).
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    sweep_state_e     state_q;
    logic [3:0]       a_q;
    logic [3:0]       hi_q;
    logic [3:0]       wait_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      prime_mask_q;
    logic [15:0]      div3_mask_q;
    logic [CNT_W-1:0] prime_cnt_q, prime_cnt_d;
    logic [CNT_W-1:0] div3_cnt_q,  div3_cnt_d;
    logic             start_ok;
    logic             sample_fire;

    // Handshake qualifiers and next counter values for a sample.
    always_comb begin
        start_ok    = (state_q == ST_IDLE) && start;
        sample_fire = (state_q == ST_SAMPLE);
        prime_cnt_d = prime_cnt_q + {{(CNT_W-1){1'b0}}, p};
        div3_cnt_d  = div3_cnt_q  + {{(CNT_W-1){1'b0}}, d};
    end

    // Sweep FSM with registered a/busy/done and result accumulation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            hi_q         <= '0;
            wait_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            prime_mask_q <= '0;
            div3_mask_q  <= '0;
            prime_cnt_q  <= '0;
            div3_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        hi_q         <= hi;
                        prime_mask_q <= '0;
                        div3_mask_q  <= '0;
                        prime_cnt_q  <= '0;
                        div3_cnt_q   <= '0;
                        if (lo <= hi) begin
                            state_q <= ST_DRIVE;
                            a_q     <= lo;
                            busy_q  <= 1'b1;
                            wait_q  <= SETTLE_LOAD;
                        end else begin
                            // Empty range: report completion without driving any code.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (wait_q == 4'd0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    prime_mask_q[a_q] <= p;
                    div3_mask_q[a_q]  <= d;
                    prime_cnt_q       <= prime_cnt_d;
                    div3_cnt_q        <= div3_cnt_d;
                    // Compare before incrementing so hi = 15 never wraps a back to 0.
                    if (a_q == hi_q) begin
                        state_q <= ST_DONE;
                        a_q     <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DRIVE;
                        a_q     <= a_q + 4'd1;
                        wait_q  <= SETTLE_LOAD;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef FUNC4_SWEEP_CHECK_EN
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             mismatch;

    // A code mismatches when either sampled flag differs from its golden bit.
    always_comb begin
        mismatch = (p != PRIME_GOLDEN[a_q]) || (d != DIV3_GOLDEN[a_q]);
    end

    // Sticky error flag and per-code mismatch count, cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (start_ok) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (sample_fire && mismatch) begin
            err_q     <= 1'b1;
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_qual;
    assign unused_qual = start_ok ^ sample_fire;
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif

    assign a          = a_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign prime_mask = prime_mask_q;
    assign div3_mask  = div3_mask_q;
    assign prime_cnt  = prime_cnt_q;
    assign div3_cnt   = div3_cnt_q;

endmodule
